morph_edge_bbox: RTL and testbench

Downstream consumer of the 3x3 grey-level dilate/erode stage. Forms the morphological gradient (dilate − erode) and binarises it against a run-time threshold to give a per-pixel edge map. It also tracks the per-frame bounding box of all edge pixels. Results feed the UDP/camera packetiser and overlay logic.

---
 rtl/morph_pkg.sv | 26 ++
 rtl/bbox_tracker.sv | 132 +++++++++++++
 rtl/morph_edge_bbox.sv | 153 +++++++++++++++
 tb/tb_morph_edge_bbox.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// -----------------------------------------------------------------------------
// morph_pkg
// Shared constants and width helpers for the morphological edge / bounding-box
// stage.
//   PIX_W     : grey-level pixel width
//   EDGE_ON   : edge_pix value for an edge pixel
//   EDGE_OFF  : edge_pix value for a non-edge pixel
//   coord_w() : bits needed for a coordinate in 0..n-1 (at least 1)
//   count_w() : bits needed for an edge count in 0..w*h
// -----------------------------------------------------------------------------
package morph_pkg;

  localparam int PIX_W = 8;

  localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

  function automatic int coord_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int count_w(input int w, input int h);
    return coord_w(w * h + 1);
  endfunction

endpackage

// File: rtl/bbox_tracker.sv
// -----------------------------------------------------------------------------
// bbox_tracker
// Accumulates the bounding box (and optionally the count) of edge pixels over a
// frame and publishes the frame results one cycle after the last pixel.
//
// Optional feature: define EDGE_COUNT_EN to add a saturating edge counter and
// the edge_count port.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   pix_vld             : one classified pixel this cycle
//   edge_flag           : that pixel is an edge
//   pix_x, pix_y        : its raster coordinates
//   pix_first/pix_last  : pixel (0,0) / pixel (W-1,H-1)
//   frame_done          : one-cycle pulse when the outputs below are updated
//   bbox_empty          : no edge pixel in the published frame
//   x_min..y_max        : inclusive bounding box (all zero when empty)
//   edge_count          : edge pixels in the published frame (EDGE_COUNT_EN)
// -----------------------------------------------------------------------------
module bbox_tracker
  import morph_pkg::*;
#(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  localparam int XW         = coord_w(IMG_WIDTH),
  localparam int YW         = coord_w(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_vld,
  input  logic          edge_flag,
  input  logic [XW-1:0] pix_x,
  input  logic [YW-1:0] pix_y,
  input  logic          pix_first,
  input  logic          pix_last,
  output logic          frame_done,
  output logic          bbox_empty,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max
`ifdef EDGE_COUNT_EN
  ,
  output logic [count_w(IMG_WIDTH, IMG_HEIGHT)-1:0] edge_count
`endif
);

`ifdef EDGE_COUNT_EN
  localparam int            CW      = count_w(IMG_WIDTH, IMG_HEIGHT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  logic [CW-1:0] run_cnt;
`endif

  logic          seen_q;
  logic          close_q;
  logic [XW-1:0] run_x_min, run_x_max;
  logic [YW-1:0] run_y_min, run_y_max;

  // Control state: seen flag, close strobe and optional counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q  <= 1'b0;
      close_q <= 1'b0;
`ifdef EDGE_COUNT_EN
      run_cnt <= '0;
`endif
    end else begin
      close_q <= pix_vld && pix_last;
      if (pix_vld) begin
        // The first pixel restarts the frame; if it is itself an edge it
        // both clears and sets seen in the same cycle.
        if (pix_first)      seen_q <= edge_flag;
        else if (edge_flag) seen_q <= 1'b1;
`ifdef EDGE_COUNT_EN
        if (pix_first)
          run_cnt <= edge_flag ? CW'(1) : '0;
        else if (edge_flag && (run_cnt != CNT_MAX))
          run_cnt <= run_cnt + CW'(1);
`endif
      end
    end
  end

  // NOTE: the running min/max registers carry no reset; they are only read
  // while seen_q is set, and seen_q forces a fresh load on the first edge.
  always_ff @(posedge clk) begin
    if (pix_vld && edge_flag) begin
      if (pix_first || !seen_q) begin
        run_x_min <= pix_x;
        run_x_max <= pix_x;
        run_y_min <= pix_y;
        run_y_max <= pix_y;
      end else begin
        if (pix_x < run_x_min) run_x_min <= pix_x;
        if (pix_x > run_x_max) run_x_max <= pix_x;
        if (pix_y < run_y_min) run_y_min <= pix_y;
        if (pix_y > run_y_max) run_y_max <= pix_y;
      end
    end
  end

  // Publish register. close_q is set the cycle after the last pixel was
  // accumulated; a next-frame first pixel arriving in that same cycle only
  // changes the running state at this edge, so the values read here are
  // still the closing frame's.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      bbox_empty <= 1'b1;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
`ifdef EDGE_COUNT_EN
      edge_count <= '0;
`endif
    end else begin
      frame_done <= close_q;
      if (close_q) begin
        bbox_empty <= !seen_q;
        x_min      <= seen_q ? run_x_min : '0;
        x_max      <= seen_q ? run_x_max : '0;
        y_min      <= seen_q ? run_y_min : '0;
        y_max      <= seen_q ? run_y_max : '0;
`ifdef EDGE_COUNT_EN
        edge_count <= run_cnt;
`endif
      end
    end
  end

endmodule

// File: rtl/morph_edge_bbox.sv
// -----------------------------------------------------------------------------
// morph_edge_bbox
// Morphological gradient (dilate - erode, saturating at 0), per-frame threshold
// binarisation into an edge map, and per-frame bounding box of edge pixels.
//
// Optional feature: define EDGE_COUNT_EN to add the edge_count port, a
// saturating per-frame count of edge pixels.
//
// Ports
//   clk, rst_n            : pixel clock, synchronous active-low reset
//   pix_en                : dilate_in/erode_in valid (raster order)
//   dilate_in, erode_in   : 3x3 max / 3x3 min of the current pixel
//   thresh                : edge threshold, captured at pixel (0,0)
//   edge_en               : edge_pix/grad_out valid (pix_en delayed 2 cycles)
//   edge_pix              : 0xFF for an edge pixel, else 0x00
//   grad_out              : raw gradient aligned with edge_pix
//   frame_done            : one-cycle pulse, frame results updated
//   bbox_empty            : no edge pixel in last frame
//   x_min, x_max          : bbox columns, inclusive
//   y_min, y_max          : bbox rows, inclusive
//   edge_count            : edge pixels in last frame (EDGE_COUNT_EN only)
// -----------------------------------------------------------------------------
module morph_edge_bbox
  import morph_pkg::*;
#(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  localparam int XW         = coord_w(IMG_WIDTH),
  localparam int YW         = coord_w(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic [PIX_W-1:0] dilate_in,
  input  logic [PIX_W-1:0] erode_in,
  input  logic [PIX_W-1:0] thresh,
  output logic             edge_en,
  output logic [PIX_W-1:0] edge_pix,
  output logic [PIX_W-1:0] grad_out,
  output logic             frame_done,
  output logic             bbox_empty,
  output logic [XW-1:0]    x_min,
  output logic [XW-1:0]    x_max,
  output logic [YW-1:0]    y_min,
  output logic [YW-1:0]    y_max
`ifdef EDGE_COUNT_EN
  ,
  output logic [count_w(IMG_WIDTH, IMG_HEIGHT)-1:0] edge_count
`endif
);

  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic             pix_first, pix_last;
  logic [PIX_W-1:0] grad_c;
  logic [PIX_W-1:0] thr_q;

  logic             s1_vld, s1_first, s1_last;
  logic [PIX_W-1:0] s1_grad;
  logic [XW-1:0]    s1_x;
  logic [YW-1:0]    s1_y;
  logic             s1_is_edge;

  assign pix_first = (x_q == '0) && (y_q == '0);
  assign pix_last  = (x_q == XW'(IMG_WIDTH - 1)) && (y_q == YW'(IMG_HEIGHT - 1));

  // erode > dilate is illegal upstream; clamp rather than wrap.
  assign grad_c = (dilate_in >= erode_in) ? (dilate_in - erode_in) : '0;

  // Raster counters; idle cycles (pix_en low) do not advance them.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pix_en) begin
      if (x_q == XW'(IMG_WIDTH - 1)) begin
        x_q <= '0;
        y_q <= (y_q == YW'(IMG_HEIGHT - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Stage 1: gradient plus pixel tags; threshold latched on pixel (0,0) so
  // that the first pixel's stage-2 compare already sees the new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_q    <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_grad  <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_vld <= pix_en;
      if (pix_en) begin
        if (pix_first) thr_q <= thresh;
        s1_first <= pix_first;
        s1_last  <= pix_last;
        s1_grad  <= grad_c;
        s1_x     <= x_q;
        s1_y     <= y_q;
      end
    end
  end

  assign s1_is_edge = (s1_grad >= thr_q);

  // Stage 2: registered edge map outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_en  <= 1'b0;
      edge_pix <= EDGE_OFF;
      grad_out <= '0;
    end else begin
      edge_en <= s1_vld;
      if (s1_vld) begin
        edge_pix <= s1_is_edge ? EDGE_ON : EDGE_OFF;
        grad_out <= s1_grad;
      end
    end
  end

  // The tracker accumulates on the same edge that registers stage 2.
  bbox_tracker #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_bbox (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_vld    (s1_vld),
    .edge_flag  (s1_is_edge),
    .pix_x      (s1_x),
    .pix_y      (s1_y),
    .pix_first  (s1_first),
    .pix_last   (s1_last),
    .frame_done (frame_done),
    .bbox_empty (bbox_empty),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max)
`ifdef EDGE_COUNT_EN
    ,
    .edge_count (edge_count)
`endif
  );

endmodule

// File: tb/tb_morph_edge_bbox.sv
// -----------------------------------------------------------------------------
// tb_morph_edge_bbox
// Self-checking bench for morph_edge_bbox on an 8x4 image. Each pixel sent is
// scored by a frame-level reference model (saturating gradient, per-frame
// threshold, bbox over the frame's edge map); a negedge monitor matches the
// DUT's output stream and frame results against the model's queues, and each
// scenario task adds its own checks on known-answer results.
// Build with +define+EDGE_COUNT_EN to also check edge_count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_morph_edge_bbox;
  import morph_pkg::*;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int XW   = coord_w(W);
  localparam int YW   = coord_w(H);
  localparam int CW   = count_w(W, H);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_en = 1'b0;
  logic [7:0]    dilate_in = '0, erode_in = '0, thresh = '0;
  logic          edge_en, frame_done, bbox_empty;
  logic [7:0]    edge_pix, grad_out;
  logic [XW-1:0] x_min, x_max;
  logic [YW-1:0] y_min, y_max;
`ifdef EDGE_COUNT_EN
  logic [CW-1:0] edge_count;
`endif

  morph_edge_bbox #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .dilate_in  (dilate_in),
    .erode_in   (erode_in),
    .thresh     (thresh),
    .edge_en    (edge_en),
    .edge_pix   (edge_pix),
    .grad_out   (grad_out),
    .frame_done (frame_done),
    .bbox_empty (bbox_empty),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max)
`ifdef EDGE_COUNT_EN
    ,
    .edge_count (edge_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] grad;
    logic [7:0] pix;
  } pix_exp_t;

  typedef struct {
    int            due;
    logic          empty;
    logic [XW-1:0] xmin, xmax;
    logic [YW-1:0] ymin, ymax;
    int            count;
  } frm_exp_t;

  pix_exp_t pix_q[$];
  frm_exp_t frm_q[$];

  int   checks = 0, failures = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  bit   rst_seen = 1'b0;
  int   idx = 0;
  logic [7:0] frame_thr = '0;
  bit   edge_map [NPIX];
  int   n_pix = 0, n_out = 0;

  logic          held_empty = 1'b1;
  logic [XW-1:0] held_xmin = '0, held_xmax = '0;
  logic [YW-1:0] held_ymin = '0, held_ymax = '0;
  int            held_cnt = 0;
  pix_exp_t      pe;
  frm_exp_t      fe;

  // ---------------------------------------------------------------- model
  function automatic frm_exp_t close_frame(input int due);
    frm_exp_t f;
    int xl = W, xh = -1, yl = H, yh = -1, c = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (edge_map[i]) begin
        if (i % W < xl) xl = i % W;
        if (i % W > xh) xh = i % W;
        if (i / W < yl) yl = i / W;
        if (i / W > yh) yh = i / W;
        c++;
      end
    end
    f.due   = due;
    f.empty = (c == 0);
    f.xmin  = (c == 0) ? '0 : XW'(xl);
    f.xmax  = (c == 0) ? '0 : XW'(xh);
    f.ymin  = (c == 0) ? '0 : YW'(yl);
    f.ymax  = (c == 0) ? '0 : YW'(yh);
    f.count = c;
    return f;
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_seen) begin
        held_empty = 1'b1;
        held_xmin = '0; held_xmax = '0; held_ymin = '0; held_ymax = '0;
        held_cnt = 0;
      end
      while (pix_q.size() > 0 && pix_q[0].due < cyc) begin
        checks++; failures++;
        $display("FAIL pix_missing cycle=%0d got no edge_en want output due at %0d", cyc, pix_q[0].due);
        void'(pix_q.pop_front());
      end
      while (frm_q.size() > 0 && frm_q[0].due < cyc) begin
        checks++; failures++;
        $display("FAIL frame_done_missing cycle=%0d got no pulse want pulse at %0d", cyc, frm_q[0].due);
        void'(frm_q.pop_front());
      end
      if (edge_en === 1'b1) begin
        n_out++;
        checks++;
        if (pix_q.size() == 0) begin
          failures++;
          $display("FAIL edge_en_unexpected cycle=%0d got edge_en=1 want 0", cyc);
        end else begin
          pe = pix_q.pop_front();
          if (pe.due != cyc || grad_out !== pe.grad || edge_pix !== pe.pix) begin
            failures++;
            $display("FAIL pixel_out cycle=%0d got grad=%0d pix=%h want cycle=%0d grad=%0d pix=%h",
                     cyc, grad_out, edge_pix, pe.due, pe.grad, pe.pix);
          end
        end
      end
      if (frame_done === 1'b1) begin
        checks++;
        if (frm_q.size() == 0) begin
          failures++;
          $display("FAIL frame_done_unexpected cycle=%0d got frame_done=1 want 0", cyc);
        end else begin
          fe = frm_q.pop_front();
          if (fe.due != cyc || bbox_empty !== fe.empty || x_min !== fe.xmin || x_max !== fe.xmax ||
              y_min !== fe.ymin || y_max !== fe.ymax) begin
            failures++;
            $display("FAIL frame_result cycle=%0d got empty=%0b x=%0d..%0d y=%0d..%0d want cycle=%0d empty=%0b x=%0d..%0d y=%0d..%0d",
                     cyc, bbox_empty, x_min, x_max, y_min, y_max,
                     fe.due, fe.empty, fe.xmin, fe.xmax, fe.ymin, fe.ymax);
          end
          held_empty = fe.empty;
          held_xmin = fe.xmin; held_xmax = fe.xmax; held_ymin = fe.ymin; held_ymax = fe.ymax;
          held_cnt = fe.count;
        end
      end
      checks++;
      if (bbox_empty !== held_empty || x_min !== held_xmin || x_max !== held_xmax ||
          y_min !== held_ymin || y_max !== held_ymax) begin
        failures++;
        $display("FAIL bbox_hold cycle=%0d got empty=%0b x=%0d..%0d y=%0d..%0d want empty=%0b x=%0d..%0d y=%0d..%0d",
                 cyc, bbox_empty, x_min, x_max, y_min, y_max,
                 held_empty, held_xmin, held_xmax, held_ymin, held_ymax);
      end
`ifdef EDGE_COUNT_EN
      checks++;
      if (edge_count !== CW'(held_cnt)) begin
        failures++;
        $display("FAIL edge_count cycle=%0d got %0d want %0d", cyc, edge_count, held_cnt);
      end
`endif
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic idle(input int n);
    pix_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] e);
    logic [7:0] g;
    pix_exp_t   p;
    int         acc;
    g = (d >= e) ? d - e : 8'd0;
    if (idx == 0) frame_thr = thresh;
    acc    = cyc + 1;
    p.due  = acc + 1;
    p.grad = g;
    p.pix  = (g >= frame_thr) ? 8'hFF : 8'h00;
    pix_q.push_back(p);
    edge_map[idx] = (g >= frame_thr);
    n_pix++;
    if (idx == NPIX - 1) frm_q.push_back(close_frame(acc + 2));
    idx = (idx + 1) % NPIX;
    pix_en = 1'b1; dilate_in = d; erode_in = e;
    @(posedge clk); #1;
    pix_en = 1'b0;
  endtask

  // Pixel with a chosen gradient on a random base level.
  task automatic send_grad(input int g);
    logic [7:0] e;
    e = 8'($urandom_range(0, 255 - g));
    send(e + 8'(g), e);
  endtask

  task automatic do_reset();
    int r;
    pix_en = 1'b0;
    rst_n  = 1'b0;
    r      = cyc + 1;
    // Anything due at or after the reset edge is discarded by the DUT.
    while (pix_q.size() > 0 && pix_q[$].due >= r) void'(pix_q.pop_back());
    while (frm_q.size() > 0 && frm_q[$].due >= r) void'(frm_q.pop_back());
    idx = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((pix_q.size() > 0 || frm_q.size() > 0) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (pix_q.size() > 0 || frm_q.size() > 0) begin
      failures++;
      $display("FAIL %s_drain got pending pix=%0d frames=%0d want 0", tag, pix_q.size(), frm_q.size());
      pix_q.delete(); frm_q.delete();
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (edge_en !== 1'b0 || edge_pix !== 8'h00 || grad_out !== 8'h00 || frame_done !== 1'b0 ||
        bbox_empty !== 1'b1 || x_min !== '0 || x_max !== '0 || y_min !== '0 || y_max !== '0) begin
      failures++;
      $display("FAIL reset_values got en=%0b pix=%h grad=%0d done=%0b empty=%0b x=%0d..%0d y=%0d..%0d want 0 00 0 0 1 0..0 0..0",
               edge_en, edge_pix, grad_out, frame_done, bbox_empty, x_min, x_max, y_min, y_max);
    end
    rst_n  = 1'b1;
    mon_on = 1'b1;
    idle(2);
  endtask

  task automatic test_all_edges();
    thresh = 8'd10;
    for (int i = 0; i < NPIX; i++) send(8'd100, 8'd90);
    wait_drain("all_edges");
    checks++;
    if (bbox_empty !== 1'b0 || x_min !== XW'(0) || x_max !== XW'(7) || y_min !== YW'(0) || y_max !== YW'(3)) begin
      failures++;
      $display("FAIL all_edges_bbox got empty=%0b x=%0d..%0d y=%0d..%0d want empty=0 x=0..7 y=0..3",
               bbox_empty, x_min, x_max, y_min, y_max);
    end
`ifdef EDGE_COUNT_EN
    checks++;
    if (edge_count !== CW'(32)) begin
      failures++;
      $display("FAIL all_edges_count got %0d want 32", edge_count);
    end
`endif
  endtask

  task automatic test_two_points();
    logic [3:0] seen_pulse;
    thresh = 8'd40;
    for (int i = 0; i < NPIX; i++)
      send_grad((i == 1 * W + 2 || i == 3 * W + 5) ? 50 : 0);
    // Last pixel accepted at the edge just passed; pulse expected 3 cycles
    // after the cycle it was presented, i.e. on the second edge from here.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      seen_pulse[k] = frame_done;
    end
    checks++;
    if (seen_pulse !== 4'b0010) begin
      failures++;
      $display("FAIL two_points_pulse got pattern=%b want 0010", seen_pulse);
    end
    wait_drain("two_points");
    checks++;
    if (bbox_empty !== 1'b0 || x_min !== XW'(2) || x_max !== XW'(5) || y_min !== YW'(1) || y_max !== YW'(3)) begin
      failures++;
      $display("FAIL two_points_bbox got empty=%0b x=%0d..%0d y=%0d..%0d want empty=0 x=2..5 y=1..3",
               bbox_empty, x_min, x_max, y_min, y_max);
    end
  endtask

  task automatic test_zero_grad();
    thresh = 8'd1;
    send(8'd100, 8'd200);
    @(posedge clk); #1;
    checks++;
    if (edge_en !== 1'b1 || grad_out !== 8'd0 || edge_pix !== 8'h00) begin
      failures++;
      $display("FAIL zero_grad_saturate got en=%0b grad=%0d pix=%h want 1 0 00", edge_en, grad_out, edge_pix);
    end
    for (int i = 1; i < NPIX; i++) begin
      if (i % 3 == 0) begin
        logic [7:0] e;
        e = 8'($urandom_range(1, 255));
        send(8'($urandom_range(0, int'(e) - 1)), e);
      end else begin
        send_grad(0);
      end
    end
    wait_drain("zero_grad");
    checks++;
    if (bbox_empty !== 1'b1 || x_min !== '0 || x_max !== '0 || y_min !== '0 || y_max !== '0) begin
      failures++;
      $display("FAIL zero_grad_bbox got empty=%0b x=%0d..%0d y=%0d..%0d want empty=1 all 0",
               bbox_empty, x_min, x_max, y_min, y_max);
    end
`ifdef EDGE_COUNT_EN
    checks++;
    if (edge_count !== CW'(0)) begin
      failures++;
      $display("FAIL zero_grad_count got %0d want 0", edge_count);
    end
`endif
  endtask

  task automatic test_thresh_change();
    thresh = 8'd30;
    for (int i = 0; i < NPIX; i++) begin
      if (i == 5) thresh = 8'd5;
      send_grad(20);
    end
    wait_drain("thresh_change_a");
    checks++;
    if (bbox_empty !== 1'b1) begin
      failures++;
      $display("FAIL thresh_change_frame1 got empty=%0b want 1", bbox_empty);
    end
    for (int i = 0; i < NPIX; i++) send_grad(20);
    wait_drain("thresh_change_b");
    checks++;
    if (bbox_empty !== 1'b0 || x_min !== XW'(0) || x_max !== XW'(7) || y_min !== YW'(0) || y_max !== YW'(3)) begin
      failures++;
      $display("FAIL thresh_change_frame2 got empty=%0b x=%0d..%0d y=%0d..%0d want empty=0 x=0..7 y=0..3",
               bbox_empty, x_min, x_max, y_min, y_max);
    end
  endtask

  task automatic send_random();
    int g;
    logic [7:0] e;
    if ($urandom_range(0, 15) == 0) begin
      e = 8'($urandom_range(1, 255));
      send(8'($urandom_range(0, int'(e) - 1)), e);
    end else begin
      g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
      send_grad(g);
    end
  endtask

  task automatic test_back_to_back();
    int p0, o0;
    p0 = n_pix; o0 = n_out;
    thresh = 8'($urandom_range(20, 200));
    for (int i = 0; i < NPIX; i++) begin
      idle($urandom_range(0, 3));
      send_random();
    end
    idle(3);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        if (i == 0 || i == 9) thresh = 8'($urandom_range(20, 200));
        send_random();
      end
    end
    wait_drain("back_to_back");
    checks++;
    if ((n_out - o0) != (n_pix - p0)) begin
      failures++;
      $display("FAIL back_to_back_count got edge_en=%0d want %0d", n_out - o0, n_pix - p0);
    end
  endtask

  task automatic test_reset_mid_frame();
    thresh = 8'd0;
    for (int i = 0; i < NPIX; i++) send_grad(int'($urandom_range(0, 255)));
    wait_drain("reset_pre");
    thresh = 8'd40;
    for (int i = 0; i < 17; i++) send_grad((i % 4 == 1) ? 60 : 0);
    do_reset();
    checks++;
    if (edge_en !== 1'b0 || edge_pix !== 8'h00 || grad_out !== 8'h00 || frame_done !== 1'b0 ||
        bbox_empty !== 1'b1 || x_min !== '0 || x_max !== '0 || y_min !== '0 || y_max !== '0) begin
      failures++;
      $display("FAIL reset_mid_values got en=%0b pix=%h grad=%0d done=%0b empty=%0b x=%0d..%0d y=%0d..%0d want 0 00 0 0 1 0..0 0..0",
               edge_en, edge_pix, grad_out, frame_done, bbox_empty, x_min, x_max, y_min, y_max);
    end
    idle(8);
    thresh = 8'd40;
    for (int i = 0; i < NPIX; i++)
      send_grad((i == 2 * W + 1 || i == 0 * W + 6) ? 60 : int'($urandom_range(0, 39)));
    wait_drain("reset_post");
    checks++;
    if (bbox_empty !== 1'b0 || x_min !== XW'(1) || x_max !== XW'(6) || y_min !== YW'(0) || y_max !== YW'(2)) begin
      failures++;
      $display("FAIL reset_post_bbox got empty=%0b x=%0d..%0d y=%0d..%0d want empty=0 x=1..6 y=0..2",
               bbox_empty, x_min, x_max, y_min, y_max);
    end
  endtask

  initial begin
    test_reset();
    test_all_edges();
    test_two_points();
    test_zero_grad();
    test_thresh_change();
    test_back_to_back();
    test_reset_mid_frame();
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
